// File: rtl/approx_divider_seq.sv
// Sequential approximate unsigned divider: leading-one segments, restoring divide, rescale.
// Build macro APPROX_DIV_ROUND_EN selects round-half-up in the rescale stage (truncation otherwise).
module approx_divider_seq #(
    parameter int WIDTH = 16,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero
);
    localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int QW  = 2 * SEG;
    localparam int QW1 = QW + 1;
    localparam int CW  = $clog2(QW + 1);
    localparam int SW  = $clog2(WIDTH + SEG + 1) + 1;
    localparam int XW  = (WIDTH > QW1) ? WIDTH : QW1;

    typedef enum logic [1:0] {S_IDLE, S_LOD, S_DIV, S_SHIFT} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic [QW-1:0]    num_q;
    logic [SEG-1:0]   den_q, rem_q;
    logic [IW-1:0]    sa_q, sb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dbz_q;

    function automatic logic [IW-1:0] lead_one(input logic [WIDTH-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    // Offset of the segment's LSB; operands narrower than SEG are kept whole.
    function automatic logic [IW-1:0] seg_offset(input logic [IW-1:0] k);
        return (int'(k) >= SEG) ? IW'(int'(k) - SEG + 1) : '0;
    endfunction

    logic [IW-1:0]  sa_d, sb_d;
    logic [SEG-1:0] m_d, n_d;

    always_comb begin
        sa_d = seg_offset(lead_one(a_q));
        sb_d = seg_offset(lead_one(b_q));
        m_d  = SEG'(a_q >> sa_d);
        n_d  = SEG'(b_q >> sb_d);
    end

    // One restoring-division step: the dividend shifts out MSB-first while
    // quotient bits shift in at the LSB of the same register.
    logic [SEG:0] trial_d, diff_d;
    logic         take_d;

    always_comb begin
        trial_d = {rem_q, num_q[QW-1]};
        diff_d  = trial_d - {1'b0, den_q};
        take_d  = (trial_d >= {1'b0, den_q});
    end

    int               sh_int_d;
    logic [SW-1:0]    sh_d;
    logic [QW:0]      rnd_d, sum_d, scaled_d;
    logic [XW-1:0]    wide_d;
    logic [WIDTH-1:0] y_d;

    always_comb begin
        sh_int_d = SEG + int'(sb_q) - int'(sa_q);
        sh_d     = (sh_int_d > 0) ? SW'(sh_int_d) : '0;
`ifdef APPROX_DIV_ROUND_EN
        rnd_d    = (sh_d != '0) ? (QW1'(1) << (sh_d - SW'(1))) : '0;
`else
        rnd_d    = '0;
`endif
        sum_d    = {1'b0, num_q} + rnd_d;
        scaled_d = sum_d >> sh_d;
        wide_d   = XW'(scaled_d);
        // A negative shift would need a left shift, which cannot be represented: saturate.
        if (sh_int_d < 0 || wide_d > XW'({WIDTH{1'b1}})) begin
            y_d = '1;
        end else begin
            y_d = WIDTH'(wide_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOD;
                    end
                end
                S_LOD: begin
                    if (b_q == '0) begin
                        y_q     <= '1;
                        dbz_q   <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        num_q   <= {m_d, {SEG{1'b0}}};
                        den_q   <= n_d;
                        rem_q   <= '0;
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= take_d ? diff_d[SEG-1:0] : trial_d[SEG-1:0];
                    num_q <= {num_q[QW-2:0], take_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    y_q     <= y_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign y           = y_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_approx_divider_seq.sv
// Scoreboard bench for approx_divider_seq: driver pushes expected results, monitor checks on done.
module tb_approx_divider_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] y;

    approx_divider_seq #(.WIDTH(16), .SEG(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

`ifdef APPROX_DIV_ROUND_EN
    localparam logic [15:0] Y_200_7 = 16'd29;
    localparam logic [15:0] Y_200_3 = 16'd67;
`else
    localparam logic [15:0] Y_200_7 = 16'd28;
    localparam logic [15:0] Y_200_3 = 16'd66;
`endif

    typedef struct {
        logic [15:0] ey;
        logic        edbz;
        int          lat;
        int          acc;
        logic [15:0] va;
        logic [15:0] vb;
    } exp_t;

    exp_t sbq[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] va, input logic [15:0] vb,
                            input logic [15:0] ey, input logic edbz, input int lat);
        exp_t e;
        e.ey = ey; e.edbz = edbz; e.lat = lat; e.acc = cyc; e.va = va; e.vb = vb;
        sbq.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        check("drain_timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] ey, input logic edbz, input int lat);
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        push_exp(va, vb, ey, edbz, lat);
        check("busy_after_accept", busy, 1);
        check("flag_cleared_on_accept", div_by_zero, 0);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got y=%0d, expected no done (cycle %0d)", y, cyc);
                end else begin
                    e = sbq.pop_front();
                    $display("[TB] txn a=%0d b=%0d -> y=%0d (exp %0d) dbz=%0b (exp %0b) latency=%0d (exp %0d)",
                             e.va, e.vb, y, e.ey, div_by_zero, e.edbz, cyc - e.acc, e.lat);
                    check("y", y, e.ey);
                    check("div_by_zero", div_by_zero, e.edbz);
                    check("latency", cyc - e.acc, e.lat);
                    check("busy_low_at_done", busy, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_y", y, 0);
        check("reset_dbz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_op(16'd200,   16'd7,     Y_200_7,    1'b0, 18);
        run_op(16'd200,   16'd3,     Y_200_3,    1'b0, 18);
        run_op(16'hFFFF,  16'd3,     16'd21760,  1'b0, 18);
        run_op(16'd1000,  16'd3,     16'd333,    1'b0, 18);
        run_op(16'hFFFF,  16'hFFFF,  16'd1,      1'b0, 18);
        run_op(16'hFFFF,  16'd1,     16'd65280,  1'b0, 18);
        run_op(16'd1234,  16'd0,     16'hFFFF,   1'b1, 1);
        repeat (3) @(posedge clk);
        #1;
        check("dbz_held", div_by_zero, 1);
        check("y_held", y, 16'hFFFF);
        run_op(16'd1234,  16'd5,     16'd246,    1'b0, 18);
        run_op(16'd0,     16'd5,     16'd0,      1'b0, 18);

        // Abort mid-division with an asynchronous reset.
        @(negedge clk);
        a = 16'd1000; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("busy_before_abort", busy, 1);
        @(posedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_y", y, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        run_op(16'd1000, 16'd3, 16'd333, 1'b0, 18);

        // start held high: the second operation is accepted right after the done cycle.
        @(negedge clk);
        a = 16'd200; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'd200, 16'd7, Y_200_7, 1'b0, 18);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("b2b_first_done_seen", seen, 1);
        a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        push_exp(16'hFFFF, 16'hFFFF, 16'd1, 1'b0, 18);
        check("b2b_accept_in_done_cycle", busy, 1);
        start = 1'b0;
        wait_drain();

        // start pulses and operand changes while busy must not disturb the operation.
        @(negedge clk);
        a = 16'hFFFF; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        push_exp(16'hFFFF, 16'd3, 16'd21760, 1'b0, 18);
        @(negedge clk);
        start = 1'b0; a = 16'd1; b = 16'd1;
        repeat (3) @(negedge clk);
        start = 1'b1; a = 16'd64; b = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (25) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
